// File: rtl/debounce_edge_detector.sv
// Debounces a synchronized input level and emits single-cycle rise/fall pulses.
// Optional rising-edge event counter on count_o when EDGE_COUNT_EN is defined.
module debounce_edge_detector #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sync_i,
    output logic             level_o,
    output logic             rise_o,
    output logic             fall_o,
`ifdef EDGE_COUNT_EN
    output logic [CNT_W-1:0] count_o,
`endif
    output logic             busy_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        CHECK_HIGH  = 2'd1,
        STABLE_HIGH = 2'd2,
        CHECK_LOW   = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    // Pulses and busy default low; each branch sets them for the state being entered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= STABLE_LOW;
            cnt     <= '0;
            level_o <= 1'b0;
            rise_o  <= 1'b0;
            fall_o  <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            rise_o <= 1'b0;
            fall_o <= 1'b0;
            busy_o <= 1'b0;
            case (state)
                STABLE_LOW: begin
                    if (sync_i) begin
                        state  <= CHECK_HIGH;
                        cnt    <= CW'(1);
                        busy_o <= 1'b1;
                    end else begin
                        cnt <= '0;
                    end
                end
                CHECK_HIGH: begin
                    if (!sync_i) begin
                        state <= STABLE_LOW;
                        cnt   <= '0;
                    end else if (cnt >= LAST) begin
                        state   <= STABLE_HIGH;
                        cnt     <= '0;
                        level_o <= 1'b1;
                        rise_o  <= 1'b1;
                    end else begin
                        cnt    <= cnt + 1'b1;
                        busy_o <= 1'b1;
                    end
                end
                STABLE_HIGH: begin
                    if (!sync_i) begin
                        state  <= CHECK_LOW;
                        cnt    <= CW'(1);
                        busy_o <= 1'b1;
                    end else begin
                        cnt <= '0;
                    end
                end
                CHECK_LOW: begin
                    if (sync_i) begin
                        state <= STABLE_HIGH;
                        cnt   <= '0;
                    end else if (cnt >= LAST) begin
                        state   <= STABLE_LOW;
                        cnt     <= '0;
                        level_o <= 1'b0;
                        fall_o  <= 1'b1;
                    end else begin
                        cnt    <= cnt + 1'b1;
                        busy_o <= 1'b1;
                    end
                end
                default: begin
                    state   <= STABLE_LOW;
                    cnt     <= '0;
                    level_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef EDGE_COUNT_EN
    // Free-running modulo-2^CNT_W count of accepted rising edges.
    always_ff @(posedge clk_i) begin
        if (rst_i)       count_o <= '0;
        else if (rise_o) count_o <= count_o + 1'b1;
    end
`endif

endmodule

// File: tb/tb_debounce_edge_detector.sv
// Directed table-driven bench for debounce_edge_detector at DEBOUNCE_CYCLES=4.
// Exercises the counter section too when built with EDGE_COUNT_EN.
module tb_debounce_edge_detector;

    localparam int DC    = 4;
    localparam int CNT_W = 8;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic sync_i = 1'b0;
    logic level_o, rise_o, fall_o, busy_o;
`ifdef EDGE_COUNT_EN
    logic [CNT_W-1:0] count_o;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    debounce_edge_detector #(.DEBOUNCE_CYCLES(DC), .CNT_W(CNT_W)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .sync_i  (sync_i),
        .level_o (level_o),
        .rise_o  (rise_o),
        .fall_o  (fall_o),
`ifdef EDGE_COUNT_EN
        .count_o (count_o),
`endif
        .busy_o  (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic rst;
        logic sync;
        logic lvl;
        logic rise;
        logic fall;
        logic busy;
    } vec_t;

    vec_t tbl[$];

    task automatic v(input logic r, s, l, ri, f, b);
        tbl.push_back('{rst: r, sync: s, lvl: l, rise: ri, fall: f, busy: b});
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // Drive inputs, clock once, sample 1 time unit after the edge.
    task automatic step(input logic r, input logic s);
        rst_i  = r;
        sync_i = s;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // rst sync | level rise fall busy  (outputs after the edge sampling this row)
        v(1,1, 0,0,0,0); v(1,1, 0,0,0,0);                                   // reset with sync high
        v(0,1, 0,0,0,1); v(0,1, 0,0,0,1); v(0,1, 0,0,0,1); v(0,1, 1,1,0,0);   // accept 4 after release
        v(0,1, 1,0,0,0); v(0,1, 1,0,0,0);
        v(0,0, 1,0,0,1); v(0,0, 1,0,0,1); v(0,0, 1,0,0,1);                   // low 3 then high
        v(0,1, 1,0,0,0); v(0,1, 1,0,0,0);
        v(0,0, 1,0,0,1); v(0,0, 1,0,0,1); v(0,0, 1,0,0,1); v(0,0, 0,0,1,0);   // clean fall
        v(0,0, 0,0,0,0);
        v(0,1, 0,0,0,1); v(0,0, 0,0,0,0); v(0,1, 0,0,0,1); v(0,1, 0,0,0,1);   // bounce 1,0,1,1,0,1,1,1,1
        v(0,0, 0,0,0,0); v(0,1, 0,0,0,1); v(0,1, 0,0,0,1); v(0,1, 0,0,0,1);
        v(0,1, 1,1,0,0); v(0,1, 1,0,0,0);
        v(0,0, 1,0,0,1); v(0,0, 1,0,0,1); v(0,0, 1,0,0,1); v(0,0, 0,0,1,0);
        v(0,0, 0,0,0,0);
        v(0,1, 0,0,0,1); v(0,1, 0,0,0,1); v(0,1, 0,0,0,1); v(0,1, 1,1,0,0);   // held high 10 cycles
        for (int i = 0; i < 6; i++) v(0,1, 1,0,0,0);
        v(0,0, 1,0,0,1); v(0,0, 1,0,0,1); v(0,0, 1,0,0,1); v(0,0, 0,0,1,0);
        v(0,0, 0,0,0,0);
        v(0,1, 0,0,0,1); v(0,1, 0,0,0,1); v(0,1, 0,0,0,1);                   // cnt=3 then reset
        v(1,1, 0,0,0,0);
        v(0,1, 0,0,0,1); v(0,1, 0,0,0,1); v(0,1, 0,0,0,1); v(0,1, 1,1,0,0);   // restart from cnt=1
        v(0,1, 1,0,0,0);
        v(1,1, 0,0,0,0); v(0,0, 0,0,0,0);                                   // reset from high: no fall

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].sync);
            chk("level_o", i, 32'(level_o), 32'(tbl[i].lvl));
            chk("rise_o",  i, 32'(rise_o),  32'(tbl[i].rise));
            chk("fall_o",  i, 32'(fall_o),  32'(tbl[i].fall));
            chk("busy_o",  i, 32'(busy_o),  32'(tbl[i].busy));
        end

        // Repeated 3-long glitches must never accumulate into an acceptance.
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < DC; k++) begin
                step(1'b0, (k < DC - 1));
                chk("glitch_level", r * DC + k, 32'(level_o), 32'd0);
                chk("glitch_rise",  r * DC + k, 32'(rise_o),  32'd0);
                chk("glitch_busy",  r * DC + k, 32'(busy_o),  32'(k < DC - 1));
            end
        end

`ifdef EDGE_COUNT_EN
        step(1'b1, 1'b0);
        chk("count_reset", 0, 32'(count_o), 32'd0);
        for (int p = 1; p <= 257; p++) begin
            for (int k = 0; k <= DC; k++) step(1'b0, 1'b1);
            for (int k = 0; k <= DC; k++) step(1'b0, 1'b0);
            if (p == 1)   chk("count_first", p, 32'(count_o), 32'd1);
            if (p == 255) chk("count_255",   p, 32'(count_o), 32'd255);
        end
        chk("count_wrap", 257, 32'(count_o), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
